// File: rtl/mult_seq_core.sv
// Sequential shift-add unsigned multiplier with a busy/done handshake.
// One partial product is accumulated per cycle; the finished product is
// held in a register and exposed one byte at a time for the 6502 read path.
module mult_seq_core #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               busy,
    output logic               done,
    output logic               valid,
    output logic [2*WIDTH-1:0] product,
    input  logic               rd_sel,
    output logic [7:0]         rd_data
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);
    // Product zero-extended to at least 16 bits so the byte mux never
    // slices past the end of a narrow product.
    localparam int EXT_W = (PW > 16) ? PW : 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_r,   state_s;
    logic [PW-1:0]     acc_r,     acc_s;
    logic [PW-1:0]     mcand_r,   mcand_s;
    logic [WIDTH-1:0]  mplier_r,  mplier_s;
    logic [CNT_W-1:0]  cnt_r,     cnt_s;
    logic [PW-1:0]     product_r, product_s;
    logic              busy_r,    busy_s;
    logic              done_r,    done_s;
    logic              valid_r,   valid_s;
    logic [PW-1:0]     sum_s;
    logic [EXT_W-1:0]  prod_ext_s;

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            acc_r     <= {PW{1'b0}};
            mcand_r   <= {PW{1'b0}};
            mplier_r  <= {WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            product_r <= {PW{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            valid_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            acc_r     <= acc_s;
            mcand_r   <= mcand_s;
            mplier_r  <= mplier_s;
            cnt_r     <= cnt_s;
            product_r <= product_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            valid_r   <= valid_s;
        end
    end

    // Next-state logic: accept start in IDLE, one shift-add step per RUN cycle.
    always_comb begin
        state_s   = state_r;
        acc_s     = acc_r;
        mcand_s   = mcand_r;
        mplier_s  = mplier_r;
        cnt_s     = cnt_r;
        product_s = product_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        valid_s   = valid_r;
        sum_s     = acc_r + (mplier_r[0] ? mcand_r : {PW{1'b0}});
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    mcand_s  = {{WIDTH{1'b0}}, op_a};
                    mplier_s = op_b;
                    acc_s    = {PW{1'b0}};
                    cnt_s    = {CNT_W{1'b0}};
                    valid_s  = 1'b0;
                    busy_s   = 1'b1;
                    state_s  = ST_RUN;
                end else begin
                    busy_s   = 1'b0;
                end
            end
            ST_RUN: begin
                acc_s    = sum_s;
                mcand_s  = mcand_r << 1;
                mplier_s = mplier_r >> 1;
                if (cnt_r == CNT_LAST) begin
                    // Final iteration: publish the sum including this step.
                    product_s = sum_s;
                    done_s    = 1'b1;
                    valid_s   = 1'b1;
                    busy_s    = 1'b0;
                    cnt_s     = {CNT_W{1'b0}};
                    state_s   = ST_IDLE;
                end else begin
                    cnt_s     = cnt_r + CNT_ONE;
                end
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // Byte read mux for the CPU data bus: low byte or second byte.
    always_comb begin
        prod_ext_s = EXT_W'(product_r);
        if (rd_sel) begin
            rd_data = prod_ext_s[15:8];
        end else begin
            rd_data = prod_ext_s[7:0];
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign valid   = valid_r;
    assign product = product_r;

endmodule

// File: tb/tb_mult_seq_core.sv
// Directed self-checking bench for mult_seq_core (WIDTH = 8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mult_seq_core;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        busy;
    logic        done;
    logic        valid;
    logic [15:0] product;
    logic        rd_sel;
    logic [7:0]  rd_data;

    int n_cmp;
    int n_bad;

    mult_seq_core #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy),
        .done    (done),
        .valid   (valid),
        .product (product),
        .rd_sel  (rd_sel),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands with start for one edge; returns at the falling edge
    // right after the accepting edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count falling edges until done is seen (bounded); 99 means timeout.
    task automatic wait_done(output int lat);
        lat = 99;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", done); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", valid); end
        n_cmp++; if (product !== 16'h0000) begin n_bad++; $display("FAIL rst_product got %h want 0000", product); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        issue(8'd12, 8'd13);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy got %b want 1", busy); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_run got %b want 0", valid); end
        wait_done(lat);
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL basic_latency got %0d want 8", lat); end
        n_cmp++; if (product !== 16'h009C) begin n_bad++; $display("FAIL basic_product got %h want 009c", product); end
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %b want 1", valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_end got %b want 0", busy); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse got %b want 0", done); end
        n_cmp++; if (product !== 16'h009C) begin n_bad++; $display("FAIL basic_hold got %h want 009c", product); end
    endtask

    task automatic test_max_bytes();
        int lat;
        issue(8'hFF, 8'hFF);
        wait_done(lat);
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL max_latency got %0d want 8", lat); end
        n_cmp++; if (product !== 16'hFE01) begin n_bad++; $display("FAIL max_product got %h want fe01", product); end
        rd_sel = 1'b0;
        #1;
        n_cmp++; if (rd_data !== 8'h01) begin n_bad++; $display("FAIL rd_lo got %h want 01", rd_data); end
        rd_sel = 1'b1;
        #1;
        n_cmp++; if (rd_data !== 8'hFE) begin n_bad++; $display("FAIL rd_hi got %h want fe", rd_data); end
        rd_sel = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero();
        int lat;
        issue(8'h00, 8'h5A);
        wait_done(lat);
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL zero_a_latency got %0d want 8", lat); end
        n_cmp++; if (product !== 16'h0000) begin n_bad++; $display("FAIL zero_a_product got %h want 0000", product); end
        @(negedge clk);
        issue(8'h5A, 8'h00);
        wait_done(lat);
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL zero_b_latency got %0d want 8", lat); end
        n_cmp++; if (product !== 16'h0000) begin n_bad++; $display("FAIL zero_b_product got %h want 0000", product); end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int n_done;
        int lat;
        n_done = 0;
        lat    = 99;
        issue(8'd3, 8'd4);
        for (int c = 1; c <= 20; c++) begin
            if (c == 3) begin
                start = 1'b1;
                op_a  = 8'd9;
                op_b  = 8'd9;
            end else begin
                start = 1'b0;
            end
            if (c == 5) op_a = 8'hA5;
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (lat == 99) lat = c;
            end
        end
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL busy_ign_latency got %0d want 8", lat); end
        n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL busy_ign_dones got %0d want 1", n_done); end
        n_cmp++; if (product !== 16'h000C) begin n_bad++; $display("FAIL busy_ign_product got %h want 000c", product); end
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(8'd7, 8'd6);
        wait_done(lat);
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL b2b_first_latency got %0d want 8", lat); end
        n_cmp++; if (product !== 16'h002A) begin n_bad++; $display("FAIL b2b_first_product got %h want 002a", product); end
        issue(8'd2, 8'd5);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept_busy got %b want 1", busy); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL b2b_valid_clear got %b want 0", valid); end
        n_cmp++; if (product !== 16'h002A) begin n_bad++; $display("FAIL b2b_product_held got %h want 002a", product); end
        wait_done(lat);
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL b2b_second_latency got %0d want 8", lat); end
        n_cmp++; if (product !== 16'h000A) begin n_bad++; $display("FAIL b2b_second_product got %h want 000a", product); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int n_done;
        n_done = 0;
        issue(8'hFF, 8'h02);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got %b want 0", valid); end
        n_cmp++; if (product !== 16'h0000) begin n_bad++; $display("FAIL midrst_product got %h want 0000", product); end
        for (int c = 1; c <= 12; c++) begin
            if (done === 1'b1) n_done++;
            @(negedge clk);
        end
        n_cmp++; if (n_done !== 0) begin n_bad++; $display("FAIL midrst_no_done got %0d want 0", n_done); end
        issue(8'hFF, 8'h02);
        wait_done(lat);
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL midrst_fresh_latency got %0d want 8", lat); end
        n_cmp++; if (product !== 16'h01FE) begin n_bad++; $display("FAIL midrst_fresh_product got %h want 01fe", product); end
        @(negedge clk);
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        start  = 1'b0;
        op_a   = 8'h00;
        op_b   = 8'h00;
        rd_sel = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_max_bytes();
        test_zero();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
